// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_pkg
// Description : Shared types and helpers for the radix-4 Booth multiplier:
//               digit encoding, digit count and default accumulator width.
// Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    // Decoded radix-4 Booth digit: sign plus magnitude select (0, 1 or 2).
    typedef struct packed {
        logic neg;
        logic zero;
        logic one;
        logic two;
    } booth_digit_t;

    // Number of radix-4 digits for an operand extended to width+2 bits.
    function automatic int booth_digits(input int width);
        return (width + 2) / 2;
    endfunction

    // Default accumulator width: full product plus 8 guard bits.
    function automatic int booth_acc_w(input int width);
        return 2 * width + 8;
    endfunction

    // Decode one overlapping 3-bit window {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_digit_t booth_encode(input logic [2:0] win);
        booth_digit_t d;
        d.neg  = win[2] & ~(win[1] & win[0]);
        d.zero = (win == 3'b000) || (win == 3'b111);
        d.one  = win[1] ^ win[0];
        d.two  = (win == 3'b011) || (win == 3'b100);
        return d;
    endfunction

endpackage : booth_pkg
`default_nettype wire

// File: rtl/booth_pp_row.sv
`default_nettype none
// ============================================================================
// Module      : booth_pp_row
// Description : One Booth partial-product row. Decodes a 3-bit multiplier
//               window and returns digit * a_ext * 4^IDX, truncated to the
//               2*WIDTH product width (two's complement, fully sign-extended).
// Revision    : 1.0 - initial release
// ============================================================================
module booth_pp_row
    import booth_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX   = 0
) (
    input  logic [2:0]         i_win,
    input  logic [WIDTH+1:0]   i_a_ext,
    output logic [2*WIDTH-1:0] o_row
);

    localparam int c_PW = 2 * WIDTH;

    booth_digit_t    w_dig;
    logic [c_PW-1:0] w_a_sx;
    logic [c_PW-1:0] w_mag;
    logic [c_PW-1:0] w_val;

    assign w_dig  = booth_encode(i_win);
    // The extended operand already carries its sign; widen it to the row width.
    assign w_a_sx = {{(c_PW - WIDTH - 2){i_a_ext[WIDTH+1]}}, i_a_ext};

    // Select magnitude, apply the digit sign, then weight by 4^IDX.
    always_comb begin
        w_mag = '0;
        if (w_dig.zero) begin
            w_mag = '0;
        end else if (w_dig.two) begin
            w_mag = {w_a_sx[c_PW-2:0], 1'b0};
        end else if (w_dig.one) begin
            w_mag = w_a_sx;
        end
        w_val = w_dig.neg ? (~w_mag + c_PW'(1)) : w_mag;
        o_row = w_val << (2 * IDX);
    end

endmodule : booth_pp_row
`default_nettype wire

// File: rtl/booth_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : booth_mul_pipe
// Description : Three-stage pipelined radix-4 Booth multiplier with
//               valid/ready flow control.
//               S1: Booth recode + partial-product rows
//               S2: carry-save (3:2) reduction to sum/carry vectors
//               S3: carry-propagate add (and optional accumulate)
//               Optional feature macro: BOOTH_MUL_ACC_EN adds acc_clr/acc and
//               a running accumulator updated on each delivered result.
// Revision    : 1.0 - initial release
// ============================================================================
module booth_mul_pipe
    import booth_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ACC_W = booth_acc_w(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
`ifdef BOOTH_MUL_ACC_EN
    input  logic               acc_clr,
    output logic [ACC_W-1:0]   acc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p
);

    localparam int c_XW = WIDTH + 2;
    localparam int c_PW = 2 * WIDTH;
    localparam int c_ND = booth_digits(WIDTH);

    if ((WIDTH < 4) || (WIDTH % 2 != 0)) begin : g_bad_width
        $error("booth_mul_pipe: WIDTH must be even and >= 4");
    end
    if (ACC_W < 2 * WIDTH) begin : g_bad_acc_w
        $error("booth_mul_pipe: ACC_W must be >= 2*WIDTH");
    end

    // ---------------- handshake: a stage loads when empty or draining -------
    logic w_en1, w_en2, w_en3;
    logic r_v1, r_v2, r_v3;

    assign w_en3    = !r_v3 || out_ready;
    assign w_en2    = !r_v2 || w_en3;
    assign w_en1    = !r_v1 || w_en2;
    assign in_ready = w_en1;

    // ---------------- S1 input: extension and Booth rows --------------------
    logic [c_XW-1:0] w_a_ext;
    logic [c_XW-1:0] w_b_ext;
    logic [c_XW:0]   w_b_win;
    logic [c_PW-1:0] w_rows [c_ND];

    assign w_a_ext = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign w_b_ext = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
    // Implicit b[-1] = 0 appended below the LSB for the first window.
    assign w_b_win = {w_b_ext, 1'b0};

    for (genvar gi = 0; gi < c_ND; gi++) begin : g_row
        booth_pp_row #(
            .WIDTH (WIDTH),
            .IDX   (gi)
        ) u_row (
            .i_win   (w_b_win[2*gi+2 -: 3]),
            .i_a_ext (w_a_ext),
            .o_row   (w_rows[gi])
        );
    end

    logic [c_PW-1:0] r_s1_rows [c_ND];

    // S1 register: capture all partial-product rows of an accepted beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            for (int k = 0; k < c_ND; k++) r_s1_rows[k] <= '0;
        end else if (w_en1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                for (int k = 0; k < c_ND; k++) r_s1_rows[k] <= w_rows[k];
            end
        end
    end

    // ---------------- S2: carry-save reduction ------------------------------
    logic [c_PW-1:0] w_csa_s;
    logic [c_PW-1:0] w_csa_c;

    // Fold rows one at a time through 3:2 compressors; carries shift left.
    always_comb begin
        w_csa_s = r_s1_rows[0];
        w_csa_c = r_s1_rows[1];
        for (int k = 2; k < c_ND; k++) begin
            logic [c_PW-1:0] t_sum;
            t_sum   = w_csa_s ^ w_csa_c ^ r_s1_rows[k];
            w_csa_c = ((w_csa_s & w_csa_c) | (w_csa_s & r_s1_rows[k]) |
                       (w_csa_c & r_s1_rows[k])) << 1;
            w_csa_s = t_sum;
        end
    end

    logic [c_PW-1:0] r_s2_s;
    logic [c_PW-1:0] r_s2_c;

    // S2 register: hold the redundant sum/carry pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_s2_s <= '0;
            r_s2_c <= '0;
        end else if (w_en2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_s2_s <= w_csa_s;
                r_s2_c <= w_csa_c;
            end
        end
    end

    // ---------------- S3: final add -----------------------------------------
    logic [c_PW-1:0] w_sum;
    logic [c_PW-1:0] r_p;

    assign w_sum = r_s2_s + r_s2_c;

    // S3 register: resolved product, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3 <= 1'b0;
            r_p  <= '0;
        end else if (w_en3) begin
            r_v3 <= r_v2;
            if (r_v2) r_p <= w_sum;
        end
    end

    assign out_valid = r_v3;
    assign p         = r_p;

`ifdef BOOTH_MUL_ACC_EN
    // Mode and restart flags ride alongside their beat through S1 and S2.
    logic             r_s1_signed, r_s1_clr;
    logic             r_s2_signed, r_s2_clr;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_acc_reg;
    logic [ACC_W-1:0] w_p_ext;
    logic [ACC_W-1:0] w_acc_base;

    // Flag pipeline, aligned with the S1/S2 data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_signed <= 1'b0;
            r_s1_clr    <= 1'b0;
            r_s2_signed <= 1'b0;
            r_s2_clr    <= 1'b0;
        end else begin
            if (w_en1 && in_valid) begin
                r_s1_signed <= is_signed;
                r_s1_clr    <= acc_clr;
            end
            if (w_en2 && r_v1) begin
                r_s2_signed <= r_s1_signed;
                r_s2_clr    <= r_s1_clr;
            end
        end
    end

    assign w_p_ext = r_s2_signed ? ACC_W'($signed(w_sum)) : ACC_W'(w_sum);
    // If the result now in S3 is being delivered this cycle, it is the
    // committed total the next beat must build on.
    assign w_acc_base = r_s2_clr ? '0 :
                        ((r_v3 && out_ready) ? r_acc : r_acc_reg);

    // Accumulator: r_acc travels with the S3 beat; r_acc_reg commits on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_acc_reg <= '0;
        end else begin
            if (r_v3 && out_ready) r_acc_reg <= r_acc;
            if (w_en3 && r_v2)     r_acc     <= w_acc_base + w_p_ext;
        end
    end

    assign acc = r_acc;
`endif

endmodule : booth_mul_pipe
`default_nettype wire

// File: tb/tb_booth_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_mul_pipe
// Description : Self-checking bench for booth_mul_pipe (WIDTH=16): directed
//               vectors, latency/throughput, stall, reset and (with
//               BOOTH_MUL_ACC_EN) accumulator sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_booth_mul_pipe;

    localparam int WIDTH = 16;
    localparam int PW    = 32;
    localparam int ACC_W = 40;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
    logic             is_signed = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [PW-1:0]    p;
`ifdef BOOTH_MUL_ACC_EN
    logic             acc_clr   = 1'b0;
    logic [ACC_W-1:0] acc;
`endif

    typedef struct {
        logic [PW-1:0]    p;
        logic             acc_chk;
        logic [ACC_W-1:0] acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   stall_cnt = 0;
    logic rnd_done  = 1'b0;

    always #5 clk = ~clk;

    booth_mul_pipe #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
`ifdef BOOTH_MUL_ACC_EN
        .acc_clr   (acc_clr),
        .acc       (acc),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] ref_mul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic s);
        longint xe, ye, pr;
        xe = s ? longint'($signed(x)) : longint'(x);
        ye = s ? longint'($signed(y)) : longint'(y);
        pr = xe * ye;
        return pr[PW-1:0];
    endfunction

    // Present one beat, wait (bounded) for acceptance, queue its expectation.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic ts,
                        input logic tclr, input logic [PW-1:0] ep,
                        input logic achk, input logic [ACC_W-1:0] eacc);
        int   n;
        exp_t e;
        n         = 0;
        a         = ta;
        b         = tb;
        is_signed = ts;
`ifdef BOOTH_MUL_ACC_EN
        acc_clr   = tclr;
`else
        if (tclr) n = 0;
`endif
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            stall_cnt++;
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check_val("send_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.p       = ep;
        e.acc_chk = achk;
        e.acc     = eacc;
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
        check_val("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: a result seen valid&&ready at negedge is consumed at the next posedge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("p", 64'(p), 64'(e.p));
`ifdef BOOTH_MUL_ACC_EN
                if (e.acc_chk) check_val("acc", 64'(acc), 64'(e.acc));
`endif
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rs;

        // ---------------- reset state ----------------
        #2;
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_p", 64'(p), 64'd0);
`ifdef BOOTH_MUL_ACC_EN
        check_val("rst_acc", 64'(acc), 64'd0);
`endif
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // ---------------- latency: 3 cycles ----------------
        a = 16'hFFFD; b = 16'h0007; is_signed = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        check_val("lat_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        exp_q.push_back('{32'hFFFF_FFEB, 1'b0, '0});
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_val("lat_c1_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check_val("lat_c2_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check_val("lat_c3_valid", 64'(out_valid), 64'd1);
        drain();

        // ---------------- directed vectors, back-to-back ----------------
        stall_cnt = 0;
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE_0001, 1'b0, '0);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 32'h0000_0001, 1'b0, '0);
        send(16'h8000, 16'h8000, 1'b1, 1'b0, 32'h4000_0000, 1'b0, '0);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, 32'h4000_0000, 1'b0, '0);
        send(16'h7FFF, 16'h8000, 1'b1, 1'b0, 32'hC000_8000, 1'b0, '0);
        send(16'h7FFF, 16'h8000, 1'b0, 1'b0, 32'h3FFF_8000, 1'b0, '0);
        send(16'h1234, 16'h5678, 1'b0, 1'b0, 32'h0626_0060, 1'b0, '0);
        send(16'h0000, 16'hFFFF, 1'b1, 1'b0, 32'h0000_0000, 1'b0, '0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 32'h0000_FFFF, 1'b0, '0);
        send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, '0);
        check_val("throughput_stalls", 64'(stall_cnt), 64'd0);
        drain();

        // ---------------- stall: 6 beats, consumer blocked ----------------
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    ra = 16'(i * 16'h0111);
                    rb = 16'(16'h0010 + i);
                    send(ra, rb, 1'b0, 1'b0, ref_mul(ra, rb, 1'b0), 1'b0, '0);
                end
            end
            begin
                repeat (4) @(negedge clk);
                check_val("stall_in_ready", 64'(in_ready), 64'd0);
                check_val("stall_out_valid", 64'(out_valid), 64'd1);
                repeat (4) begin
                    @(negedge clk);
                    check_val("stall_p_hold", 64'(p), 64'(32'h0000_0111 * 32'h0000_0011));
                    check_val("stall_valid_hold", 64'(out_valid), 64'd1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // ---------------- random beats with random backpressure ----------------
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    ra = 16'($urandom);
                    rb = 16'($urandom);
                    rs = 1'($urandom_range(0, 1));
                    send(ra, rb, rs, 1'b0, ref_mul(ra, rb, rs), 1'b0, '0);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // ---------------- reset with beats in flight ----------------
        out_ready = 1'b0;
        send(16'h0003, 16'h0005, 1'b0, 1'b0, 32'd15, 1'b0, '0);
        send(16'h0007, 16'h0009, 1'b0, 1'b0, 32'd63, 1'b0, '0);
        @(posedge clk);
        #1;
        check_val("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_val("mid_rst_valid", 64'(out_valid), 64'd0);
        check_val("mid_rst_p", 64'(p), 64'd0);
`ifdef BOOTH_MUL_ACC_EN
        check_val("mid_rst_acc", 64'(acc), 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check_val("post_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (5) begin
            @(negedge clk);
            check_val("post_rst_no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(16'h0100, 16'h0100, 1'b0, 1'b0, 32'h0001_0000, 1'b0, '0);
        drain();

`ifdef BOOTH_MUL_ACC_EN
        // ---------------- accumulator sequence ----------------
        send(16'd2,    16'd3,    1'b1, 1'b1, 32'd6,         1'b1, 40'd6);
        send(16'd4,    16'd5,    1'b1, 1'b0, 32'd20,        1'b1, 40'd26);
        send(16'hFFFF, 16'd1,    1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 40'd25);
        send(16'h7FFF, 16'h7FFF, 1'b1, 1'b1, 32'h3FFF_0001, 1'b1, 40'h00_3FFF_0001);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        check_val("watchdog", 64'd0, 64'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_booth_mul_pipe
`default_nettype wire
